// File: rtl/can_tx_mailbox_sched_pkg.sv
// can_defs: shared CAN frame descriptor type and arbitration key helper
package can_defs;
  typedef struct packed {
    logic            ide;
    logic [10:0]     id_std;
    logic [17:0]     id_ext;
    logic            rtr;
    logic [3:0]      dlc;
    logic [7:0][7:0] data;
  } can_frame_desc_s;
  // Lower key wins; the ide/srr bits make std data < std remote < extended with the same base id
  function automatic logic [31:0] can_arb_key(input can_frame_desc_s d);
    return d.ide ? {d.id_std, 1'b1, 1'b1, d.id_ext, d.rtr} : {d.id_std, d.rtr, 1'b0, 18'b0, 1'b0};
  endfunction
endpackage

// File: rtl/can_prio_select.sv
// can_prio_select: picks the pending mailbox with the lowest arbitration key, lowest index on ties
module can_prio_select #(
  parameter int NUM_MB = 4,
  parameter int IDX_W  = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]       pending,
  input  logic [NUM_MB-1:0][31:0] keys,
  output logic [IDX_W-1:0]        idx,
  output logic                    valid
);
  logic [31:0] best;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    best = '1;
    for (int i = 0; i < NUM_MB; i++)
      if (pending[i] && (!valid || keys[i] < best)) begin
        idx = IDX_W'(i);
        valid = 1'b1;
        best = keys[i];
      end
  end
endmodule

// File: rtl/can_tx_mailbox_sched.sv
// can_tx_mailbox_sched: multi-mailbox CAN transmit scheduler with retry and abort handling
import can_defs::*;
module can_tx_mailbox_sched #(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 0,
  parameter int IDX_W     = $clog2(NUM_MB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_MB-1:0] mb_load,
  input  logic              load_ide,
  input  logic [10:0]       load_id_std,
  input  logic [17:0]       load_id_ext,
  input  logic              load_rtr,
  input  logic [3:0]        load_dlc,
  input  logic [63:0]       load_data,
  input  logic [NUM_MB-1:0] mb_abort,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [NUM_MB-1:0] mb_done,
  output logic [NUM_MB-1:0] mb_fail,
  input  logic              bus_idle,
  output logic              start_tx,
  output logic              tx_ide,
  output logic [10:0]       tx_id_std,
  output logic [17:0]       tx_id_ext,
  output logic              tx_rtr,
  output logic [3:0]        tx_dlc,
  output logic [63:0]       tx_data,
  input  logic              tx_done,
  input  logic              arb_lost,
  input  logic              tx_error,
  output logic [IDX_W-1:0]  active_mb,
  output logic              busy
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int RC_W = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [0:0]               state;
  can_frame_desc_s          mb [NUM_MB];
  can_frame_desc_s          load_desc, tx_desc;
  logic [NUM_MB-1:0]        pending, act_oh, ld, ab, pending_nxt, done_nxt, fail_nxt;
  logic [NUM_MB-1:0][31:0]  keys;
  logic [IDX_W-1:0]         sel_idx, sel_idx_c;
  logic                     sel_valid, sel_valid_c;
  logic [RC_W-1:0]          retry, retry_nxt;
  logic                     abort_hold, abort_act, fin_done, fin_err, fin_arb, fin, err_fail, drop, launch;
  assign busy = state == S_WAIT;
  assign mb_pending = pending;
  assign load_desc = '{ide: load_ide, id_std: load_id_std, id_ext: load_id_ext, rtr: load_rtr, dlc: load_dlc, data: load_data};
  assign {tx_ide, tx_id_std, tx_id_ext, tx_rtr, tx_dlc, tx_data} = tx_desc;
  always_comb begin
    keys = '0;
    for (int i = 0; i < NUM_MB; i++) keys[i] = can_arb_key(mb[i]);
  end
  can_prio_select #(.NUM_MB(NUM_MB), .IDX_W(IDX_W)) u_sel (
    .pending(pending),
    .keys(keys),
    .idx(sel_idx_c),
    .valid(sel_valid_c)
  );
  // Completion priority: done > error > arb_lost; abort on the active mailbox only takes effect on non-success
  always_comb begin
    act_oh = busy ? NUM_MB'(1) << active_mb : '0;
    ld = mb_load & ~mb_abort & ~act_oh;
    ab = mb_abort & pending & ~act_oh;
    fin_done = busy & tx_done;
    fin_err = busy & ~tx_done & tx_error;
    fin_arb = busy & ~tx_done & ~tx_error & arb_lost;
    fin = fin_done | fin_err | fin_arb;
    abort_act = abort_hold | (busy & mb_abort[active_mb]);
    retry_nxt = retry + RC_W'(1);
    err_fail = fin_err && MAX_RETRY != 0 && retry_nxt == RC_W'(MAX_RETRY);
    drop = fin_done | ((fin_err | fin_arb) & abort_act) | err_fail;
    pending_nxt = (pending | ld) & ~ab & ~(drop ? act_oh : '0);
    done_nxt = fin_done ? act_oh : '0;
    fail_nxt = ab | ((drop & ~fin_done) ? act_oh : '0);
    // Skip a stale selection whose mailbox just left, or is being aborted or rewritten this cycle
    launch = !busy && sel_valid && bus_idle && pending[sel_idx] && !mb_abort[sel_idx] && !mb_load[sel_idx];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      for (int i = 0; i < NUM_MB; i++) mb[i] <= '0;
      pending <= '0;
      sel_idx <= '0;
      sel_valid <= 1'b0;
      tx_desc <= '0;
      active_mb <= '0;
      start_tx <= 1'b0;
      mb_done <= '0;
      mb_fail <= '0;
      retry <= '0;
      abort_hold <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MB; i++) if (ld[i]) mb[i] <= load_desc;
      pending <= pending_nxt;
      sel_idx <= sel_idx_c;
      sel_valid <= sel_valid_c;
      mb_done <= done_nxt;
      mb_fail <= fail_nxt;
      start_tx <= launch;
      abort_hold <= busy && !fin && abort_act;
      retry <= drop ? '0 : fin_err ? retry_nxt : (launch && sel_idx != active_mb) ? '0 : retry;
      if (launch) begin
        tx_desc <= mb[sel_idx];
        active_mb <= sel_idx;
        state <= S_WAIT;
      end else if (fin) state <= S_IDLE;
    end
endmodule

// File: tb/tb_can_tx_mailbox_sched.sv
// tb_can_tx_mailbox_sched: directed checks of mailbox scheduling, retry, abort and reset
module tb_can_tx_mailbox_sched;
  logic clk = 0, rst = 1;
  logic [3:0] mb_load = 0, mb_abort = 0, mb_pending, mb_done, mb_fail;
  logic load_ide = 0, load_rtr = 0, bus_idle = 0, start_tx, tx_ide, tx_rtr, tx_done = 0, arb_lost = 0, tx_error = 0, busy;
  logic [10:0] load_id_std = 0, tx_id_std;
  logic [17:0] load_id_ext = 0, tx_id_ext;
  logic [3:0] load_dlc = 0, tx_dlc;
  logic [63:0] load_data = 0, tx_data;
  logic [1:0] active_mb;
  int errors = 0, checks = 0;
  can_tx_mailbox_sched #(.NUM_MB(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .mb_load(mb_load), .load_ide(load_ide), .load_id_std(load_id_std),
    .load_id_ext(load_id_ext), .load_rtr(load_rtr), .load_dlc(load_dlc), .load_data(load_data),
    .mb_abort(mb_abort), .mb_pending(mb_pending), .mb_done(mb_done), .mb_fail(mb_fail),
    .bus_idle(bus_idle), .start_tx(start_tx), .tx_ide(tx_ide), .tx_id_std(tx_id_std),
    .tx_id_ext(tx_id_ext), .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_done(tx_done), .arb_lost(arb_lost), .tx_error(tx_error), .active_mb(active_mb), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [3:0] m, input logic ide, input logic [10:0] sid, input logic [17:0] eid, input logic rtr);
    mb_load = m; load_ide = ide; load_id_std = sid; load_id_ext = eid; load_rtr = rtr;
    step();
    mb_load = 0;
  endtask
  task automatic wait_start(input string tag, input logic [1:0] exp_mb);
    int n = 0;
    do begin step(); n++; end while (!start_tx && n < 12);
    chk({tag, "_start"}, start_tx, 1);
    chk({tag, "_mb"}, active_mb, exp_mb);
  endtask
  task automatic pulse(input logic d, input logic e, input logic a);
    tx_done = d; tx_error = e; arb_lost = a;
    step();
    tx_done = 0; tx_error = 0; arb_lost = 0;
  endtask
  task automatic no_start(input string tag, input int n);
    logic seen = 0;
    for (int i = 0; i < n; i++) begin step(); seen |= start_tx; end
    chk(tag, seen, 0);
  endtask
  initial begin
    step(); step();
    rst = 0;
    step();
    chk("rst_pending", mb_pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_tx, 0);
    chk("rst_done_fail", {mb_done, mb_fail}, 0);
    // Single frame: launch two cycles after the load lands
    bus_idle = 1;
    load_dlc = 4'd8; load_data = 64'h8877665544332211;
    load(4'b0100, 0, 11'h123, 0, 0);
    chk("s1_pend", mb_pending, 4'b0100);
    step();
    chk("s1_early", start_tx, 0);
    step();
    chk("s1_start", start_tx, 1);
    chk("s1_mb", active_mb, 2);
    chk("s1_id", tx_id_std, 11'h123);
    chk("s1_data", tx_data, 64'h8877665544332211);
    chk("s1_busy", busy, 1);
    pulse(1, 0, 0);
    chk("s1_done", mb_done, 4'b0100);
    chk("s1_pend0", mb_pending, 0);
    step();
    chk("s1_done_pulse", mb_done, 0);
    // Priority: std 0x100 < ext base 0x100 < std 0x200
    bus_idle = 0;
    load(4'b0001, 0, 11'h200, 0, 0);
    load(4'b0010, 0, 11'h100, 0, 0);
    load(4'b1000, 1, 11'h100, 18'h00001, 0);
    bus_idle = 1;
    wait_start("s2a", 1);
    pulse(1, 0, 0);
    wait_start("s2b", 3);
    chk("s2b_ide", {tx_ide, tx_id_std, tx_id_ext}, {1'b1, 11'h100, 18'h00001});
    pulse(1, 0, 0);
    wait_start("s2c", 0);
    pulse(1, 0, 0);
    step();
    chk("s2_empty", mb_pending, 0);
    // Equal keys: lower index first; load to the active mailbox is ignored
    load(4'b1001, 0, 11'h055, 0, 0);
    wait_start("s3a", 0);
    load(4'b0001, 0, 11'h7ff, 0, 0);
    chk("s3_hold_id", tx_id_std, 11'h055);
    pulse(1, 0, 0);
    chk("s3_pend", mb_pending, 4'b1000);
    wait_start("s3b", 3);
    pulse(1, 0, 0);
    // Abort of a pending non-active mailbox
    bus_idle = 0;
    load(4'b0100, 0, 11'h010, 0, 0);
    mb_abort = 4'b0100;
    step();
    mb_abort = 0;
    chk("ab_fail", mb_fail, 4'b0100);
    chk("ab_pend", mb_pending, 0);
    // Retry limit 3; arb_lost does not count
    bus_idle = 1;
    load(4'b0010, 0, 11'h010, 0, 0);
    wait_start("r0", 1);
    pulse(0, 1, 0);
    chk("r1_fail", mb_fail, 0);
    wait_start("r1", 1);
    pulse(0, 0, 1);
    chk("ra_fail", mb_fail, 0);
    wait_start("ra", 1);
    pulse(0, 1, 0);
    chk("r2_fail", mb_fail, 0);
    wait_start("r2", 1);
    pulse(0, 1, 0);
    chk("r3_fail", mb_fail, 4'b0010);
    chk("r3_pend", mb_pending, 0);
    no_start("r3_nostart", 5);
    // Abort of active: done wins; arb_lost turns it into a fail
    load(4'b0001, 0, 11'h030, 0, 0);
    wait_start("aa", 0);
    mb_abort = 4'b0001;
    step();
    mb_abort = 0;
    pulse(1, 0, 0);
    chk("aa_done", {mb_done, mb_fail}, {4'b0001, 4'b0000});
    load(4'b0001, 0, 11'h030, 0, 0);
    wait_start("ab", 0);
    mb_abort = 4'b0001;
    step();
    mb_abort = 0;
    pulse(0, 0, 1);
    chk("ab_arb", {mb_done, mb_fail}, {4'b0000, 4'b0001});
    no_start("ab_nostart", 5);
    // Reset during transmission
    bus_idle = 0;
    load(4'b1111, 0, 11'h044, 0, 0);
    bus_idle = 1;
    wait_start("rs", 0);
    rst = 1;
    #1;
    chk("rs_out", {mb_pending, mb_done, mb_fail, start_tx, busy, active_mb}, 0);
    step();
    rst = 0;
    chk("rs_pulses", {mb_done, mb_fail}, 0);
    no_start("rs_nostart", 5);
    chk("rs_empty", mb_pending, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
